// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver, LSB first.
// The line is resynchronised into the clk domain, and an FSM samples each bit
// in the middle of its period. Finished bytes are offered on a valid/ready
// handshake. Framing errors and overruns are reported as single-cycle pulses.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       data_ready,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    // Baud counter terminal values.
    // The start-bit check happens half a bit in; data and stop bits are
    // sampled one full bit period apart after that.
    localparam logic [13:0] CNT_LAST  = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Two-flop synchroniser. rx_s is the only view of the line that the FSM uses.
    logic        rx_p0;
    logic        rx_s;

    logic [13:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;

    // Decoded strobes from the output-decode process.
    logic        bit_tick;    // mid-bit sample point of a data bit
    logic        stop_tick;   // mid-bit sample point of the stop bit
    logic        byte_done;   // stop bit sampled high: frame is good
    logic        frame_bad;   // stop bit sampled low: framing error

    // --- stage: line synchroniser ---
    // Bring the asynchronous rxd into the clk domain. The flops reset to the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rxd;
            rx_s  <= rx_p0;
        end
    end

    // --- stage: frame FSM ---
    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. All decisions use the synchronised line.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // If the line is high again half a bit in, it was a glitch.
                if (cnt == HALF_LAST) begin
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if ((cnt == CNT_LAST) && (bit_idx == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    state_d = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // A line held low must not retrigger a start bit. Wait for it to go high.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: busy flag and sample strobes derived from the registered state.
    always_comb begin
        busy      = 1'b0;
        bit_tick  = 1'b0;
        stop_tick = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if (state_q != S_IDLE) begin
            busy = 1'b1;
        end
        if ((state_q == S_DATA) && (cnt == CNT_LAST)) begin
            bit_tick = 1'b1;
        end
        if ((state_q == S_STOP) && (cnt == CNT_LAST)) begin
            stop_tick = 1'b1;
        end
        byte_done = stop_tick & rx_s;
        frame_bad = stop_tick & ~rx_s;
    end

    // Baud counter: clears on every state change and wraps at the end of each bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 14'd0;
        end else if (state_d != state_q) begin
            cnt <= 14'd0;
        end else if ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)) begin
            if (cnt == CNT_LAST) begin
                cnt <= 14'd0;
            end else begin
                cnt <= cnt + 14'd1;
            end
        end else begin
            cnt <= 14'd0;
        end
    end

    // Bit index: held at zero outside DATA and advanced on each data sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx <= 3'd0;
        end else if (state_q != S_DATA) begin
            bit_idx <= 3'd0;
        end else if (bit_tick) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // --- stage: data capture ---
    // The shift register takes each sampled bit in at the MSB, so after eight
    // samples the first bit on the line (LSB) ends up at bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= 8'd0;
        end else if (bit_tick) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

    // --- stage: output handshake ---
    // Deliver completed bytes and generate the error pulses.
    // A byte is accepted only if the holding register is empty or is being
    // drained in this same cycle. Otherwise the new byte is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data          <= 8'd0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data       <= shift_reg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives 8N1 frames into uart_receiver (16 clocks per bit).
// Expected bytes go into a scoreboard queue as each frame is sent, and are
// popped when the DUT transfers a byte. Table vectors cover normal and
// framing-error frames. Hand-written sequences cover the glitch, overrun,
// handshake-collision and mid-frame reset cases.
module tb_uart_receiver;

    localparam int C         = 16;
    localparam int H         = 8;
    localparam int DONE_EDGE = 2 + H + 9 * C;   // stop-sample edge after the start edge

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       data_ready;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    uart_receiver #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .data_ready   (data_ready),
        .data         (data),
        .data_valid   (data_valid),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    typedef struct {
        logic [7:0] val;
        logic       stop;
        int         exp_fe;
        int         exp_bytes;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         frame_e0 = 0;
    logic [7:0] sb_q[$];
    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         rise_cnt = 0;
    int         last_rise = 0;
    int         valid_len = 0;
    int         fe_cnt = 0;
    int         last_fe = 0;
    int         ovr_cnt = 0;
    int         last_ovr = 0;
    logic       prev_valid;
    logic       prev_xfer;
    logic       prev_fe;
    logic       prev_ovr;
    logic [7:0] prev_data;
    vec_t       vecs[6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required end before it", $time);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Must be called just after a posedge. The next posedge is edge 0 of the frame.
    // A low stop bit leaves the line low, and the caller releases it.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        frame_e0 = cyc + 1;
        rxd = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        sb_q.push_back(b);
        push_cnt++;
    endtask

    // Monitor: samples on the falling edge, scoreboards transfers and checks pulse rules.
    initial begin
        logic [7:0] exp;
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        prev_fe    = 1'b0;
        prev_ovr   = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 1'b0;
                prev_xfer  = 1'b0;
                prev_fe    = 1'b0;
                prev_ovr   = 1'b0;
            end else begin
                if (prev_valid && !prev_xfer) begin
                    check("data_hold", int'(data), int'(prev_data));
                    check("valid_hold", int'(data_valid), 1);
                end
                if (data_valid && !prev_valid) begin
                    rise_cnt++;
                    last_rise = cyc;
                    valid_len = 0;
                end
                if (data_valid) valid_len++;
                if (framing_error) begin
                    fe_cnt++;
                    last_fe = cyc;
                    check("fe_width", int'(prev_fe), 0);
                end
                if (overrun) begin
                    ovr_cnt++;
                    last_ovr = cyc;
                    check("ovr_width", int'(prev_ovr), 0);
                end
                if (framing_error || overrun) begin
                    check("fe_ovr_excl", int'(framing_error && overrun), 0);
                end
                prev_xfer = data_valid && data_ready;
                if (prev_xfer) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_byte", int'(data), -1);
                    end else begin
                        exp = sb_q.pop_front();
                        pop_cnt++;
                        check("sb_data", int'(data), int'(exp));
                    end
                end
                prev_valid = data_valid;
                prev_data  = data;
                prev_fe    = framing_error;
                prev_ovr   = overrun;
            end
        end
    end

    initial begin
        int fe0;
        int r0;
        int o0;
        int e2;

        vecs[0] = '{val: 8'hA5, stop: 1'b1, exp_fe: 0, exp_bytes: 1};
        vecs[1] = '{val: 8'h00, stop: 1'b1, exp_fe: 0, exp_bytes: 1};
        vecs[2] = '{val: 8'hFF, stop: 1'b1, exp_fe: 0, exp_bytes: 1};
        vecs[3] = '{val: 8'h3C, stop: 1'b0, exp_fe: 1, exp_bytes: 0};
        vecs[4] = '{val: 8'h81, stop: 1'b1, exp_fe: 0, exp_bytes: 1};
        vecs[5] = '{val: 8'h6E, stop: 1'b1, exp_fe: 0, exp_bytes: 1};

        // Reset state
        reset      = 1'b0;
        rxd        = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_fe", int'(framing_error), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Table-driven frames with data_ready held high
        data_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            r0  = rise_cnt;
            o0  = ovr_cnt;
            if (vecs[i].exp_bytes != 0) expect_byte(vecs[i].val);
            send_frame(vecs[i].val, vecs[i].stop);
            if (!vecs[i].stop) begin
                repeat (40) @(posedge clk);
                #1;
                check("break_busy", int'(busy), 1);
                rxd = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                check("break_idle", int'(busy), 0);
            end
            repeat (4) @(posedge clk);
            #1;
            check("vec_fe_count", fe_cnt - fe0, vecs[i].exp_fe);
            check("vec_valid_rises", rise_cnt - r0, vecs[i].exp_bytes);
            check("vec_ovr_count", ovr_cnt - o0, 0);
            if (vecs[i].exp_bytes != 0) begin
                check("vec_valid_edge", last_rise - frame_e0, DONE_EDGE);
                check("vec_valid_len", valid_len, 1);
            end else begin
                check("vec_fe_edge", last_fe - frame_e0, DONE_EDGE);
            end
            check("vec_valid_idle", int'(data_valid), 0);
        end

        // Glitch: line low for 4 clocks only
        fe0 = fe_cnt;
        r0  = rise_cnt;
        o0  = ovr_cnt;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        @(negedge clk);
        check("glitch_busy", int'(busy), 1);
        repeat (12) @(posedge clk);
        #1;
        check("glitch_idle", int'(busy), 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_ovr", ovr_cnt - o0, 0);
        check("glitch_valid", rise_cnt - r0, 0);

        // Overrun: two bytes back to back with nobody accepting
        data_ready = 1'b0;
        o0 = ovr_cnt;
        expect_byte(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        e2 = frame_e0;
        repeat (2) @(posedge clk);
        #1;
        check("ovr_count", ovr_cnt - o0, 1);
        check("ovr_edge", last_ovr - e2, DONE_EDGE);
        check("ovr_data_kept", int'(data), 8'h11);
        check("ovr_valid_kept", int'(data_valid), 1);
        data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_drain", int'(data_valid), 0);

        // Handshake collision: accept the old byte on the cycle the new one completes
        data_ready = 1'b0;
        o0 = ovr_cnt;
        expect_byte(8'h33);
        send_frame(8'h33, 1'b1);
        expect_byte(8'h44);
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (DONE_EDGE) @(posedge clk);
                #1 data_ready = 1'b1;
                @(posedge clk);
                #1 data_ready = 1'b0;
            end
        join
        check("coll_data", int'(data), 8'h44);
        check("coll_valid", int'(data_valid), 1);
        check("coll_ovr", ovr_cnt - o0, 0);
        data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("coll_drain", int'(data_valid), 0);

        // Reset in the middle of DATA (three bits of 0xF0 sent), then a clean frame
        @(posedge clk);
        #1;
        fe0 = fe_cnt;
        o0  = ovr_cnt;
        r0  = rise_cnt;
        rxd = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b0;
            repeat (C) @(posedge clk);
            #1;
        end
        check("mid_busy", int'(busy), 1);
        reset = 1'b0;
        rxd   = 1'b1;
        @(negedge clk);
        check("mid_rst_data", int'(data), 0);
        check("mid_rst_valid", int'(data_valid), 0);
        check("mid_rst_fe", int'(framing_error), 0);
        check("mid_rst_ovr", int'(overrun), 0);
        check("mid_rst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_fe", fe_cnt - fe0, 0);
        check("post_rst_ovr", ovr_cnt - o0, 0);
        check("post_rst_valid", rise_cnt - r0, 0);
        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_edge", last_rise - frame_e0, DONE_EDGE);
        check("post_rst_rises", rise_cnt - r0, 1);

        // Every expected byte must have been delivered
        check("sb_left", sb_q.size(), 0);
        check("sb_pops", pop_cnt, push_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 framing, LSB first; the receive-side companion to the transmitter stage.
- Consumes the serial line driven by the transmitter (loopback or external pin) and delivers bytes over a valid/ready handshake.
- Default timing is 9600 baud at 100 MHz (10416 clocks per bit), so it is bit-compatible with the transmitter's baud generator.

Parameters:
- CLKS_PER_BIT, 10416: clock cycles per bit period. Must be ≥4. Use 16 in simulation.
- HALF_BIT, CLKS_PER_BIT/2: start-bit validation point, in cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset. Asserting it clears all state immediately.
- rxd  in  1  serial input; idles high; asynchronous to clk.
- data_ready  in  1  consumer accepts data this cycle.
- data  out  8  received byte. Stable while data_valid=1.
- data_valid  out  1  byte available; held until accepted.
- framing_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the previous byte was still unaccepted.
- busy  out  1  high whenever state≠IDLE.

Behaviour:
- Reset values:
  - data=0, data_valid=0, framing_error=0, overrun=0, busy=0.
  - Both synchronizer flops=1, state=IDLE, counters=0.
- Reset mid-frame aborts the frame silently. No flags are raised on release.
- Synchronizer: 2-flop synchronizer on rxd produces rx_s. All FSM decisions use rx_s only.
- Bit counter (bit_idx): 3 bits, counts 0..7.
- Baud counter (cnt): 14 bits, counts 0..CLKS_PER_BIT-1, reset to 0 on every state change.
- FSM states and transitions:
  - IDLE: cnt=0. On rx_s=0 → START.
  - START: cnt increments each cycle. At cnt==HALF_BIT-1:
    - rx_s=0 → DATA, with cnt=0 and bit_idx=0.
    - rx_s=1 → IDLE. This is a glitch: no flags, no output change.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift), clear cnt, increment bit_idx. After the sample with bit_idx==7 → STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: byte complete → IDLE.
    - rx_s=0: framing_error pulses for the next cycle and the byte is discarded → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. This prevents a held-low line from retriggering START.
- Timing: sampling is mid-bit. Let edge 0 be the first clk edge at which rxd is low. The stop bit is sampled at edge 2+HALF_BIT+9*CLKS_PER_BIT, and data_valid/data update on that same edge.
- Handshake:
  - A transfer occurs on any cycle with data_valid=1 and data_ready=1. data_valid clears on the next edge unless a new byte completes on that edge.
  - data_ready while data_valid=0 has no effect.
  - data does not change while data_valid=1, except when a new byte is loaded in the same cycle the old byte is transferred.
- Byte completion:
  - If data_valid=0, or data_valid=1 with data_ready=1: load data and set data_valid=1. No overrun.
  - If data_valid=1 with data_ready=0: overrun pulses for one cycle. The new byte is dropped; the old data and data_valid are retained.
- framing_error and overrun are never asserted in the same cycle.
- busy reflects the registered state; it is 0 only in IDLE.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8, bit period = 16 clk):
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1), stop=1, data_ready held 1 → data_valid high for exactly 1 cycle at edge 154 after the start edge, data=0xA5, no flags.
- Glitch: rxd low for 4 clk, then high → FSM returns to IDLE, busy pulses then clears, data_valid, framing_error and overrun stay 0.
- Frame 0x3C with stop bit driven 0, line held low 40 clk, then high → framing_error one-cycle pulse, data_valid stays 0, no new START until the line returns high; a following 0x81 frame is received correctly.
- Back-to-back 0x11 then 0x22 with data_ready=0 → data=0x11 held valid, overrun pulses at the 0x22 stop sample, data remains 0x11; raising data_ready then clears data_valid on the next edge.
- Handshake collision: data_ready asserted exactly on the cycle the second byte completes → data=second byte, data_valid stays 1, overrun=0.
- Reset asserted mid-DATA (after 3 bits of 0xF0), released, then a clean 0x5A frame → all outputs 0 during reset, no flags after release, 0x5A received correctly.
